// File: rtl/count_run_controller.sv
// rtl/count_run_controller.sv - tick generator, button debounce and run/pause/clear control for the event counter
module count_run_controller #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int TICK_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int WIDTH          = 16
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic             btn_start_stop,
  input  logic             btn_clear,
  input  logic             sw_dir,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic [1:0]       state,
  output logic             tick,
  output logic             wrap
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       raw_btn;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       db_level;
  logic [DB_W-1:0]  db_cnt [2];
  logic [1:0]       press;
  logic             press_ss;
  logic             press_clr;
  state_t           state_r;
  state_t           state_nxt;

  // tick is registered one cycle early so it is high exactly while div_cnt == DIV-1
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      if (div_cnt == DIV_W'(DIV - 1)) div_cnt <= '0;
      else                            div_cnt <= div_cnt + DIV_W'(1);
      tick <= (div_cnt == DIV_W'(DIV - 2));
    end
  end

  assign raw_btn = {btn_clear, btn_start_stop};

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_btn;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      db_level <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_TICKS - 1)) begin
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // press fires on the tick that accepts a rising debounced level
  always_comb begin
    press = '0;
    for (int i = 0; i < 2; i++) begin
      press[i] = tick && sync2[i] && !db_level[i] &&
                 (db_cnt[i] == DB_W'(DEBOUNCE_TICKS - 1));
    end
  end

  assign press_ss  = press[0];
  assign press_clr = press[1];

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE:  if (press_ss) state_nxt = S_RUN;
      S_RUN:   if (press_ss) state_nxt = S_PAUSE;
      S_PAUSE: if (press_ss) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
    if (press_clr) state_nxt = S_IDLE;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_r <= S_IDLE;
      running <= 1'b0;
    end else begin
      state_r <= state_nxt;
      running <= (state_nxt == S_RUN);
    end
  end

  assign state = state_r;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (press_clr) begin
        count <= '0;
      end else if ((state_r == S_RUN) && tick) begin
        if (sw_dir) begin
          count <= count - WIDTH'(1);
          wrap  <= (count == '0);
        end else begin
          count <= count + WIDTH'(1);
          wrap  <= (count == '1);
        end
      end
    end
  end

endmodule

// File: tb/tb_count_run_controller.sv
// tb/tb_count_run_controller.sv - randomized and directed bench for count_run_controller
module tb_count_run_controller;

  localparam int DIV = 10;
  localparam int DEB = 3;
  localparam int W   = 4;
  localparam int MAXV = (1 << W);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bss = 1'b0;
  logic         bcl = 1'b0;
  logic         dir = 1'b0;
  logic [W-1:0] count;
  logic         running;
  logic [1:0]   state;
  logic         tick;
  logic         wrap;

  count_run_controller #(
    .CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_TICKS(DEB), .WIDTH(W)
  ) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .btn_start_stop(bss), .btn_clear(bcl),
    .sw_dir(dir), .count(count), .running(running), .state(state), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int m_cyc, m_state, m_cnt, m_wrap, m_tick;
  int m_s1 [2];
  int m_s2 [2];
  int m_db [2];
  int m_run [2];
  int saw_up_wrap, saw_down_wrap, ticks_seen, first_tick, calls;
  int hold_ss, held_cnt;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_cyc = 0; m_state = 0; m_cnt = 0; m_wrap = 0; m_tick = 0;
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0;
    end
  endtask

  // advance the reference by one clock using the inputs currently applied
  task automatic model_step();
    int b [2];
    int pr [2];
    int tk, nxt;
    b[0] = int'(bss);
    b[1] = int'(bcl);
    tk = (m_cyc % DIV == DIV - 1);
    for (int i = 0; i < 2; i++) begin
      pr[i] = 0;
      if (tk) begin
        if (m_s2[i] == m_db[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_db[i] = m_s2[i];
            m_run[i] = 0;
            pr[i] = m_db[i];
          end
        end
      end
    end
    m_wrap = 0;
    if (pr[1] == 1) begin
      m_cnt = 0;
      m_state = 0;
    end else begin
      if (m_state == 1 && tk == 1) begin
        nxt = dir ? m_cnt - 1 : m_cnt + 1;
        m_wrap = (nxt < 0 || nxt >= MAXV);
        m_cnt = (nxt + MAXV) % MAXV;
      end
      if (pr[0] == 1) m_state = (m_state == 1) ? 2 : 1;
    end
    for (int i = 0; i < 2; i++) begin
      m_s2[i] = m_s1[i];
      m_s1[i] = b[i];
    end
    m_cyc++;
    m_tick = (m_cyc % DIV == DIV - 1);
  endtask

  task automatic compare_all();
    check_eq("tick", int'(tick), m_tick);
    check_eq("count", int'(count), m_cnt);
    check_eq("state", int'(state), m_state);
    check_eq("running", int'(running), int'(m_state == 1));
    check_eq("wrap", int'(wrap), m_wrap);
  endtask

  task automatic step_cycle();
    if (!rst_n) model_reset();
    else model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    calls++;
    if (wrap && count == 0) saw_up_wrap = 1;
    if (wrap && count == W'(MAXV - 1)) saw_down_wrap = 1;
    if (tick) begin
      ticks_seen++;
      if (first_tick < 0) first_tick = calls;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_count", int'(count), 0);
    check_eq("rst_state", int'(state), 0);
    run(n);
    rst_n = 1'b1;
  endtask

  task automatic press(input int which, input int hold);
    if (which == 0) bss = 1'b1; else bcl = 1'b1;
    run(hold);
    if (which == 0) bss = 1'b0; else bcl = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset(3);

    calls = 0; ticks_seen = 0; first_tick = -1;
    run(25);
    check_eq("ticks_in_25", ticks_seen, 2);
    check_eq("first_tick_cycle", first_tick + 1, 10);

    dir = 1'b0;
    saw_up_wrap = 0;
    press(0, 50);
    check_eq("start_run", int'(state), 1);
    for (int i = 0; i < 300 && !saw_up_wrap; i++) step_cycle();
    check_eq("up_wrap_seen", saw_up_wrap, 1);
    for (int i = 0; i < 200 && count != 5; i++) step_cycle();
    check_eq("reach_5", int'(count), 5);

    press(0, 10);
    run(40);
    check_eq("glitch_ignored", int'(state), 1);
    press(0, 50);
    run(5);
    check_eq("pause", int'(state), 2);
    held_cnt = int'(count);
    run(100);
    check_eq("pause_hold", int'(count), held_cnt);

    dir = 1'b1;
    saw_down_wrap = 0;
    press(0, 50);
    check_eq("resume", int'(state), 1);
    for (int i = 0; i < 400 && !saw_down_wrap; i++) step_cycle();
    check_eq("down_wrap_seen", saw_down_wrap, 1);

    bss = 1'b1; bcl = 1'b1;
    run(50);
    bss = 1'b0; bcl = 1'b0;
    run(5);
    check_eq("both_state", int'(state), 0);
    check_eq("both_count", int'(count), 0);
    press(1, 50);
    run(5);
    check_eq("idle_clear_count", int'(count), 0);

    dir = 1'b0;
    press(0, 50);
    run(60);
    bss = 1'b1;
    run(15);
    do_reset(3);
    run(25);
    check_eq("held_no_early_press", int'(state), 0);
    run(10);
    check_eq("held_press_after_reset", int'(state), 1);
    bss = 1'b0;
    run(20);

    hold_ss = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_ss == 0) begin
        bss = 1'($urandom_range(0, 1));
        hold_ss = $urandom_range(1, 60);
      end else hold_ss--;
      if (i % 20 == 0) bcl = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      if ($urandom_range(0, 999) == 0) do_reset($urandom_range(1, 3));
      else step_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
